data_mem_responder: RTL and testbench

Byte-serial data-memory responder: the memory-side end of the processor's word-wide data-memory port. It accepts 32-bit word read/write requests over a valid/ready handshake and serves each one from a byte-wide storage array, one byte per cycle, in big-endian order. The most significant byte is at the lowest address, matching the processor's data memory layout. It replaces the ideal single-cycle data array with a realistic multi-cycle target, so processor-side stall logic can be exercised.

---
 rtl/dmr_pkg.sv | 35 +++
 rtl/data_mem_responder_byte_ram.sv | 24 ++
 rtl/data_mem_responder.sv | 124 ++++++++++++
 tb/tb_data_mem_responder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/dmr_pkg.sv
// Shared definitions for the byte-serial data-memory responder.
package dmr_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } dmr_state_e;

  // Big-endian: beat 0 carries the most significant byte (lane 3).
  function automatic logic [1:0] beat_lane(input logic [1:0] beat);
    return 2'd3 - beat;
  endfunction

  // Extract the byte of a word that travels on a given beat.
  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] beat);
    logic [1:0] lane;
    lane = beat_lane(beat);
    return word[int'(lane) * 8 +: 8];
  endfunction

  // Replace the byte of a word that travels on a given beat.
  function automatic logic [31:0] set_byte(input logic [31:0] word, input logic [1:0] beat,
                                           input logic [7:0] value);
    logic [31:0] result;
    logic [1:0]  lane;
    lane   = beat_lane(beat);
    result = word;
    result[int'(lane) * 8 +: 8] = value;
    return result;
  endfunction

endpackage

// File: rtl/data_mem_responder_byte_ram.sv
// Byte-wide single-port storage: synchronous write, combinational read, no reset.
module byte_ram #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);

  logic [7:0] mem_r [DEPTH];

  // Store one byte on enabled clock edges; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
  end

  assign rdata = mem_r[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder: accepts word requests and serves them one byte per cycle.
module data_mem_responder
  import dmr_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [31:0]       rsp_rdata
);

  dmr_state_e        state_r;
  dmr_state_e        state_s;
  logic              accept_s;
  logic              req_ready_s;
  logic              rsp_valid_s;
  logic [1:0]        beat_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r;
  logic              write_r;
  logic [31:0]       rdata_r;
  logic              req_ready_r;
  logic              rsp_valid_r;
  logic [ADDR_W-1:0] ram_addr_s;
  logic              ram_we_s;
  logic [7:0]        ram_wdata_s;
  logic [7:0]        ram_rdata_s;

  // Next-state decode; handshake outputs are precomputed here and registered.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid && req_ready_r) begin
          state_s  = XFER;
          accept_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      XFER: begin
        if (beat_r == 2'd3) begin
          state_s = RESP;
        end else begin
          state_s = XFER;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    req_ready_s = (state_s == IDLE);
    rsp_valid_s = (state_s == RESP);
  end

  // Byte address wraps naturally modulo DEPTH; reset blocks the write of the current beat.
  assign ram_addr_s  = addr_r + {{(ADDR_W-2){1'b0}}, beat_r};
  assign ram_we_s    = (state_r == XFER) && write_r && !reset;
  assign ram_wdata_s = word_byte(wdata_r, beat_r);

  byte_ram #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we_s),
    .addr (ram_addr_s),
    .wdata(ram_wdata_s),
    .rdata(ram_rdata_s)
  );

  // State, request capture, beat counting and read-data assembly.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      beat_r      <= 2'd0;
      addr_r      <= '0;
      wdata_r     <= 32'h0000_0000;
      write_r     <= 1'b0;
      rdata_r     <= 32'h0000_0000;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      req_ready_r <= req_ready_s;
      rsp_valid_r <= rsp_valid_s;
      if (accept_s) begin
        addr_r  <= req_addr;
        wdata_r <= req_wdata;
        write_r <= req_write;
        beat_r  <= 2'd0;
        rdata_r <= 32'h0000_0000;
      end else if (state_r == XFER) begin
        beat_r <= beat_r + 2'd1;
        if (!write_r) begin
          rdata_r <= set_byte(rdata_r, beat_r, ram_rdata_s);
        end
      end
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_write = write_r;
  assign rsp_rdata = rdata_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [4:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_write;
  logic [31:0] rsp_rdata;

  int checks = 0;
  int errors = 0;

  data_mem_responder #(.DEPTH(32), .ADDR_W(5)) u_dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata)
  );

  always #5 clk = ~clk;

  // Issue one request with rsp_ready high; lat = edges from accept to rsp_valid (-1 on timeout).
  task automatic do_req(input logic w, input logic [4:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic rw, output int lat);
    int cyc;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 5'd0; req_wdata = 32'h0;
    cyc = 0;
    while (!rsp_valid && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    lat = rsp_valid ? cyc : -1;
    rd  = rsp_rdata;
    rw  = rsp_write;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata: got %h expected 0", rsp_rdata); end
    checks++; if (rsp_write !== 1'b0) begin errors++; $display("FAIL reset_rsp_write: got %b expected 0", rsp_write); end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL idle_req_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic rw; int lat;
    do_req(1'b1, 5'h04, 32'hDEADBEEF, rd, rw, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL wr_latency: got %0d expected 4", lat); end
    checks++; if (rw !== 1'b1) begin errors++; $display("FAIL wr_rsp_write: got %b expected 1", rw); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL wr_rdata_zero: got %h expected 0", rd); end
    checks++;
    if ({u_dut.u_ram.mem_r[4], u_dut.u_ram.mem_r[5], u_dut.u_ram.mem_r[6], u_dut.u_ram.mem_r[7]} !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wr_bytes_4_7: got %h%h%h%h expected deadbeef", u_dut.u_ram.mem_r[4],
               u_dut.u_ram.mem_r[5], u_dut.u_ram.mem_r[6], u_dut.u_ram.mem_r[7]);
    end
    do_req(1'b0, 5'h04, 32'h0, rd, rw, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL rd_latency: got %0d expected 4", lat); end
    checks++; if (rw !== 1'b0) begin errors++; $display("FAIL rd_rsp_write: got %b expected 0", rw); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h expected deadbeef", rd); end
  endtask

  task automatic test_wrap();
    logic [31:0] rd; logic rw; int lat;
    do_req(1'b1, 5'h1E, 32'h11223344, rd, rw, lat);
    checks++;
    if ({u_dut.u_ram.mem_r[30], u_dut.u_ram.mem_r[31], u_dut.u_ram.mem_r[0], u_dut.u_ram.mem_r[1]} !== 32'h11223344) begin
      errors++;
      $display("FAIL wrap_bytes: got %h%h%h%h expected 11223344", u_dut.u_ram.mem_r[30],
               u_dut.u_ram.mem_r[31], u_dut.u_ram.mem_r[0], u_dut.u_ram.mem_r[1]);
    end
    do_req(1'b0, 5'h1E, 32'h0, rd, rw, lat);
    checks++; if (rd !== 32'h11223344) begin errors++; $display("FAIL wrap_read: got %h expected 11223344", rd); end
  endtask

  task automatic test_backpressure();
    int bad;
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 5'h04;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_rsp_valid: got %b expected 1", rsp_valid); end
    checks++; if (rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL bp_rdata: got %h expected deadbeef", rsp_rdata); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        req_valid = 1'b1; req_write = 1'b1; req_addr = 5'h00; req_wdata = 32'hFFFFFFFF;
      end else begin
        req_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || req_ready !== 1'b0 || rsp_write !== 1'b0) begin
        bad++;
      end
    end
    req_valid = 1'b0;
    checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad); end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b expected 0", rsp_valid); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", req_ready); end
    checks++; if (u_dut.u_ram.mem_r[0] !== 8'h33) begin errors++; $display("FAIL bp_ignored_write: got %h expected 33", u_dut.u_ram.mem_r[0]); end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] rd; logic rw; int lat; int seen;
    do_req(1'b1, 5'h08, 32'h00000000, rd, rw, lat);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 5'h08; req_wdata = 32'hAABBCCDD;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b expected 1", req_ready); end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid === 1'b1) seen++;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rst_mid_no_rsp: got %0d response cycles expected 0", seen); end
    do_req(1'b0, 5'h08, 32'h0, rd, rw, lat);
    checks++; if (rd !== 32'hAABB0000) begin errors++; $display("FAIL rst_mid_read: got %h expected aabb0000", rd); end
  endtask

  task automatic test_back_to_back();
    logic        w_tab [3] = '{1'b0, 1'b1, 1'b0};
    logic [4:0]  a_tab [3] = '{5'h04, 5'h10, 5'h10};
    logic [31:0] d_tab [3] = '{32'h0, 32'hCAFEF00D, 32'h0};
    logic [31:0] e_tab [3] = '{32'hDEADBEEF, 32'h0, 32'hCAFEF00D};
    int acc_cyc [3];
    int rsp_cyc [3];
    logic [31:0] rsp_d [3];
    logic        rsp_w [3];
    int idx, nrsp, cyc;
    idx = 0; nrsp = 0; cyc = 0;
    while (nrsp < 3 && cyc < 60) begin
      if (rsp_valid === 1'b1) begin
        rsp_cyc[nrsp] = cyc; rsp_d[nrsp] = rsp_rdata; rsp_w[nrsp] = rsp_write;
        nrsp++;
      end
      if (req_ready === 1'b1 && idx < 3) begin
        req_valid = 1'b1; req_write = w_tab[idx]; req_addr = a_tab[idx]; req_wdata = d_tab[idx];
        acc_cyc[idx] = cyc + 1;
        idx++;
      end else if (idx == 3 && req_ready !== 1'b1) begin
        req_valid = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    req_valid = 1'b0;
    checks++; if (nrsp !== 3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", nrsp); end
    for (int i = 0; i < nrsp; i++) begin
      checks++; if (rsp_d[i] !== e_tab[i]) begin errors++; $display("FAIL b2b_data%0d: got %h expected %h", i, rsp_d[i], e_tab[i]); end
      checks++; if (rsp_w[i] !== w_tab[i]) begin errors++; $display("FAIL b2b_write%0d: got %b expected %b", i, rsp_w[i], w_tab[i]); end
      checks++; if (rsp_cyc[i] - acc_cyc[i] !== 4) begin errors++; $display("FAIL b2b_lat%0d: got %0d expected 4", i, rsp_cyc[i] - acc_cyc[i]); end
    end
    for (int i = 1; i < idx; i++) begin
      checks++; if (acc_cyc[i] - acc_cyc[i-1] !== 6) begin errors++; $display("FAIL b2b_spacing%0d: got %0d expected 6", i, acc_cyc[i] - acc_cyc[i-1]); end
    end
  endtask

  task automatic test_unaligned();
    logic [31:0] rd; logic rw; int lat;
    do_req(1'b1, 5'h00, 32'h01020304, rd, rw, lat);
    do_req(1'b1, 5'h04, 32'h05060708, rd, rw, lat);
    do_req(1'b0, 5'h02, 32'h0, rd, rw, lat);
    checks++; if (rd !== 32'h03040506) begin errors++; $display("FAIL unaligned_read: got %h expected 03040506", rd); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL unaligned_latency: got %0d expected 4", lat); end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 5'd0;
    req_wdata = 32'h0; rsp_ready = 1'b1;
    #1;
    test_reset();
    test_write_read();
    test_wrap();
    test_backpressure();
    test_reset_mid_write();
    test_back_to_back();
    test_unaligned();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
